xor_checksum: RTL and testbench
===============================

XOR_CHECKSUM -- requirements
Module: xor_checksum

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits, legal range 1..64.
REQ-002 SHALL have parameter MAX_WORDS, default 16: maximum words per frame, legal range 2..256.
REQ-003 SHALL have localparam CNT_W = $clog2(MAX_WORDS+1): word-count width.
REQ-004 SHALL have CLK  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have RST  input  1: synchronous reset, active-high, sampled on CLK rising edge.
REQ-006 SHALL have IN_VALID  input  1: the upstream source presents a word.
REQ-007 SHALL have IN_READY  output  1: the block accepts a word this cycle.
REQ-008 SHALL have IN_DATA  input  WIDTH: the input word.
REQ-009 SHALL have IN_LAST  input  1: the presented word is the final word of the frame.
REQ-010 SHALL have OUT_VALID  output  1: the frame result is available.
REQ-011 SHALL have OUT_READY  input  1: the downstream sink takes the result.
REQ-012 SHALL have OUT_SUM  output  WIDTH: bitwise XOR of all accepted words in the frame.
REQ-013 SHALL have OUT_PARITY  output  1: XOR-reduction of OUT_SUM.
REQ-014 SHALL have OUT_COUNT  output  CNT_W: number of words accepted in the frame.
REQ-015 SHALL have OUT_OVF  output  1: the frame was truncated at MAX_WORDS without IN_LAST.

Function
REQ-016 SHALL implement states IDLE, ACCUM and DONE, all registered.
REQ-017 SHALL define input accept as IN_VALID and IN_READY high in the same cycle.
REQ-018 SHALL define output accept as OUT_VALID and OUT_READY high in the same cycle.
REQ-019 SHALL drive IN_READY=1 in IDLE and ACCUM, and IN_READY=0 in DONE; IN_READY SHALL be a function of state only.
REQ-020 SHALL, on an accept in IDLE, load sum=IN_DATA and count=1 (no XOR with stale sum).
REQ-021 SHALL, on an accept in ACCUM, update sum=sum^IN_DATA and count=count+1.
REQ-022 SHALL, on an accepted word with IN_LAST=1, enter DONE on the next edge with OUT_OVF=0.
REQ-023 SHALL, on an accepted word with IN_LAST=0 and no overflow, move IDLE->ACCUM or stay in ACCUM.
REQ-024 SHALL, when an accepted word makes count equal MAX_WORDS with IN_LAST=0, enter DONE with OUT_OVF=1.
REQ-025 SHALL, when the MAX_WORDS-th accepted word has IN_LAST=1, enter DONE with OUT_OVF=0 (exact fit is not overflow).
REQ-026 SHALL give a latency of one cycle: OUT_VALID rises in the cycle after the last word is accepted.
REQ-027 SHALL hold OUT_VALID, OUT_SUM, OUT_PARITY, OUT_COUNT and OUT_OVF stable in DONE until an output accept.
REQ-028 SHALL, on an output accept, return to IDLE, clear OUT_VALID next cycle, and make IN_READY=1 next cycle.
REQ-029 SHALL drive OUT_VALID=0 outside DONE; OUT_SUM, OUT_COUNT and OUT_OVF are don't-care outside DONE but SHALL be deterministic.
REQ-030 SHALL not change any state while IN_VALID=0 in IDLE or ACCUM (stall cycles are allowed mid-frame).
REQ-031 SHALL ignore IN_DATA and IN_LAST while IN_VALID=0 or in DONE.
REQ-032 SHALL treat a single-word frame (IN_LAST on the first word) as OUT_SUM=that word and OUT_COUNT=1.

Reset
REQ-033 SHALL, while RST=1, force state=IDLE, sum=0, count=0, OUT_VALID=0, OUT_OVF=0 and IN_READY=0.
REQ-034 SHALL give RST priority over any handshake in the same cycle; a frame in progress or a pending result is discarded.
REQ-035 SHALL drive IN_READY=1 in the first cycle after RST deasserts.

Verification
REQ-036 SHALL cover a basic frame: WIDTH=8, words 0x0F, 0xF0, 0x3C (last), OUT_READY=1 -> OUT_VALID one cycle after third accept, OUT_SUM=0xC3, OUT_PARITY=0, OUT_COUNT=3, OUT_OVF=0.
REQ-037 SHALL cover overflow: MAX_WORDS=4 with 4 words 0x01, 0x02, 0x04, 0x08 and IN_LAST=0 -> OUT_SUM=0x0F, OUT_COUNT=4, OUT_OVF=1, IN_READY=0 until the output accept.
REQ-038 SHALL cover exact fit: MAX_WORDS=4 with 4th word IN_LAST=1 -> OUT_OVF=0, OUT_COUNT=4.
REQ-039 SHALL cover backpressure: OUT_READY=0 for 5 cycles -> outputs stable and IN_READY=0 throughout; accept on cycle 6 -> IDLE, then next frame's first word 0xAA yields OUT_SUM=0xAA (no carry-over).
REQ-040 SHALL cover stall and reset: IN_VALID gaps mid-frame -> result unchanged; RST asserted mid-frame after 2 words -> OUT_VALID=0, and the next frame 0x55 (last) gives OUT_SUM=0x55, OUT_COUNT=1.

Source files
------------

// File: rtl/xor_checksum.sv
// Frame XOR checksum: XORs the words of a valid/ready input frame and presents the sum,
// its parity, the word count and a truncation flag as one held result per frame.
module xor_checksum #(
   parameter int WIDTH     = 32,
   parameter int MAX_WORDS = 16,
   localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_parity,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   sum_reg, sum_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               ovf_reg, ovf_next;

   logic               in_accept;
   logic [WIDTH-1:0]   word_sum;
   logic [CNT_W-1:0]   word_count;

   // Ready is gated by reset so no word can be taken while the block is being cleared.
   assign in_ready  = !rst && (state_reg != DONE);
   assign in_accept = in_valid && in_ready;

   // The first word of a frame loads the accumulator instead of folding into the old sum.
   assign word_sum   = (state_reg == IDLE) ? in_data    : (sum_reg ^ in_data);
   assign word_count = (state_reg == IDLE) ? CNT_W'(1)  : (count_reg + CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         sum_reg   <= '0;
         count_reg <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         sum_reg   <= sum_next;
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sum_next   = sum_reg;
      count_next = count_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         IDLE, ACCUM: begin
            if (in_accept) begin
               sum_next   = word_sum;
               count_next = word_count;
               ovf_next   = 1'b0;
               if (in_last) begin
                  state_next = DONE;
               end else if (word_count == CNT_W'(MAX_WORDS)) begin
                  // Frame hit capacity without a last marker: close it as truncated.
                  state_next = DONE;
                  ovf_next   = 1'b1;
               end else begin
                  state_next = ACCUM;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign out_valid  = (state_reg == DONE);
   assign out_sum    = sum_reg;
   assign out_parity = ^sum_reg;
   assign out_count  = count_reg;
   assign out_ovf    = ovf_reg;

endmodule

// File: tb/tb_xor_checksum.sv
// Directed bench for xor_checksum with WIDTH=8, MAX_WORDS=4; each task drives one
// scenario and compares the outputs against hand-computed values.
module tb_xor_checksum;

   localparam int W  = 8;
   localparam int MW = 4;
   localparam int CW = $clog2(MW + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_sum;
   logic          out_parity;
   logic [CW-1:0] out_count;
   logic          out_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   xor_checksum #(.WIDTH(W), .MAX_WORDS(MW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_parity (out_parity),
      .out_count  (out_count),
      .out_ovf    (out_ovf)
   );

   // Presents one word for one clock edge; inputs change 1 time unit after the edge.
   task automatic push(input logic [W-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'hEE;
      $display("push data=%02h last=%0b", d, last);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(2);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
      n_checks++; if (out_sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got=%02h want=00", out_sum); end
      n_checks++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", out_count); end
      n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%0b want=0", out_ovf); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%0b want=1", in_ready); end
      $display("test_reset done");
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      push(8'h0F, 1'b0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%0b want=0", out_valid); end
      push(8'hF0, 1'b0);
      push(8'h3C, 1'b1);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%0b want=1", out_valid); end
      n_checks++; if (out_sum !== 8'hC3) begin n_fail++; $display("FAIL basic_sum got=%02h want=c3", out_sum); end
      n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL basic_parity got=%0b want=0", out_parity); end
      n_checks++; if (out_count !== 3'd3) begin n_fail++; $display("FAIL basic_count got=%0d want=3", out_count); end
      n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%0b want=0", out_ovf); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_done got=%0b want=0", in_ready); end
      idle(1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain_valid got=%0b want=0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_drain_ready got=%0b want=1", in_ready); end
      out_ready = 1'b0;
      $display("test_basic done sum=%02h count=%0d", out_sum, out_count);
   endtask

   task automatic test_overflow;
      push(8'h01, 1'b0);
      push(8'h02, 1'b0);
      push(8'h04, 1'b0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_early_valid got=%0b want=0", out_valid); end
      push(8'h08, 1'b0);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hFF;
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready got=%0b want=0", in_ready); end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got=%0b want=1", out_valid); end
         n_checks++; if (out_sum !== 8'h0F) begin n_fail++; $display("FAIL ovf_sum got=%02h want=0f", out_sum); end
         n_checks++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got=%0d want=4", out_count); end
         n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%0b want=1", out_ovf); end
         idle(1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_valid got=%0b want=0", out_valid); end
      $display("test_overflow done");
   endtask

   task automatic test_exact_fit;
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b0);
      push(8'h44, 1'b1);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fit_valid got=%0b want=1", out_valid); end
      n_checks++; if (out_sum !== 8'h44) begin n_fail++; $display("FAIL fit_sum got=%02h want=44", out_sum); end
      n_checks++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL fit_count got=%0d want=4", out_count); end
      n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL fit_ovf got=%0b want=0", out_ovf); end
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      $display("test_exact_fit done");
   endtask

   task automatic test_back_to_back;
      push(8'h5A, 1'b0);
      push(8'h3C, 1'b1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h99;
         in_last  = 1'b1;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%0b want=1", i, out_valid); end
         n_checks++; if (out_sum !== 8'h66) begin n_fail++; $display("FAIL bp_sum cyc=%0d got=%02h want=66", i, out_sum); end
         n_checks++; if (out_count !== 3'd2) begin n_fail++; $display("FAIL bp_count cyc=%0d got=%0d want=2", i, out_count); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%0b want=0", i, in_ready); end
         idle(1);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid got=%0b want=0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain_ready got=%0b want=1", in_ready); end
      push(8'hAA, 1'b1);
      n_checks++; if (out_sum !== 8'hAA) begin n_fail++; $display("FAIL bp_next_sum got=%02h want=aa", out_sum); end
      n_checks++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL bp_next_count got=%0d want=1", out_count); end
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      $display("test_back_to_back done");
   endtask

   task automatic test_stall;
      push(8'h01, 1'b0);
      in_data = 8'hFF;
      in_last = 1'b1;
      idle(3);
      in_last = 1'b0;
      push(8'h80, 1'b0);
      idle(2);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_early_valid got=%0b want=0", out_valid); end
      push(8'h10, 1'b1);
      n_checks++; if (out_sum !== 8'h91) begin n_fail++; $display("FAIL stall_sum got=%02h want=91", out_sum); end
      n_checks++; if (out_parity !== 1'b1) begin n_fail++; $display("FAIL stall_parity got=%0b want=1", out_parity); end
      n_checks++; if (out_count !== 3'd3) begin n_fail++; $display("FAIL stall_count got=%0d want=3", out_count); end
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      $display("test_stall done");
   endtask

   task automatic test_reset_mid;
      push(8'h77, 1'b0);
      push(8'h66, 1'b0);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h12;
      in_last  = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got=%0b want=0", in_ready); end
      idle(1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%0b want=0", out_valid); end
      n_checks++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count got=%0d want=0", out_count); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_release_ready got=%0b want=1", in_ready); end
      push(8'h55, 1'b1);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_valid got=%0b want=1", out_valid); end
      n_checks++; if (out_sum !== 8'h55) begin n_fail++; $display("FAIL rstmid_next_sum got=%02h want=55", out_sum); end
      n_checks++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL rstmid_next_count got=%0d want=1", out_count); end
      n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_ovf got=%0b want=0", out_ovf); end
      // A pending result must also be discarded by reset.
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstdone_valid got=%0b want=0", out_valid); end
      $display("test_reset_mid done");
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_overflow();
      test_exact_fit();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
